// File: rtl/peripheral_ctrl_pkg.sv
// Shared constants for the peripheral I/O controller and its channel debouncers.
package peripheral_ctrl_pkg;

    localparam int NUM_CHANNELS = 4;
    localparam int INDEX_WIDTH  = 2;

    // Channel numbers double as the peripherals read address for that input.
    localparam logic [INDEX_WIDTH-1:0] CH_ANALOG_25 = 2'd0;
    localparam logic [INDEX_WIDTH-1:0] CH_ANALOG_26 = 2'd1;
    localparam logic [INDEX_WIDTH-1:0] CH_BUTTON_1  = 2'd2;
    localparam logic [INDEX_WIDTH-1:0] CH_BUTTON_2  = 2'd3;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX   = CH_BUTTON_2;

    // Controller states, kept as plain constants so older tools can read them.
    typedef logic [1:0] state_t;
    localparam state_t IDLE       = 2'd0;
    localparam state_t CPU_ACCESS = 2'd1;
    localparam state_t RESPOND    = 2'd2;
    localparam state_t SCAN       = 2'd3;

endpackage

// File: rtl/peripheral_io_controller_debouncer.sv
// Per-channel debouncer: the stable level flips only after DEBOUNCE_COUNT
// consecutive samples disagree with it; a 0->1 flip pulses rise.
module channel_debouncer #(
    parameter int DEBOUNCE_COUNT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sample_valid,
    input  logic sample,
    output logic stable,
    output logic rise
);

    localparam logic [3:0] LAST_COUNT = 4'(DEBOUNCE_COUNT - 1);

    logic [3:0] count_q, count_d;
    logic       stable_q, stable_d;
    logic       flip;

    // Count disagreeing samples and flip the stable level when the run completes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        count_d  = count_q;
        stable_d = stable_q;
        flip     = 1'b0;
        if (sample_valid) begin
            if (sample == stable_q) begin
                count_d = '0;
            end else if (count_q == LAST_COUNT) begin
                flip     = 1'b1;
                stable_d = ~stable_q;
                count_d  = '0;
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    // Debounce state registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its pre-edge inputs, independent of statement order.
        if (!reset_n) begin
            count_q  <= '0;
            stable_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
    assign rise   = flip & sample;

endmodule

// File: rtl/peripheral_io_controller.sv
// Owns the peripherals port: arbitrates CPU loads/stores against a periodic
// four-channel input scan, debounces the inputs and latches rising-edge events.
module peripheral_io_controller
    import peripheral_ctrl_pkg::*;
#(
    parameter int SCAN_INTERVAL  = 1000,
    parameter int DEBOUNCE_COUNT = 4,
    parameter int MAX_WAIT       = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cpu_request,
    input  logic                    cpu_write,
    input  logic [31:0]             cpu_address,
    input  logic [31:0]             cpu_data,
    output logic                    cpu_ready,
    output logic [31:0]             cpu_read_data,
    output logic [31:0]             periph_address,
    output logic [31:0]             periph_data,
    output logic                    periph_should_write,
    input  logic [31:0]             periph_read_data,
    input  logic [NUM_CHANNELS-1:0] event_clear,
    input  logic [NUM_CHANNELS-1:0] irq_mask,
    output logic [NUM_CHANNELS-1:0] event_pending,
    output logic [NUM_CHANNELS-1:0] debounced_level,
    output logic                    irq
);

    localparam int IW = $clog2(SCAN_INTERVAL);
    localparam int WW = $clog2(MAX_WAIT + 1) + 1;
    localparam logic [IW-1:0] INTERVAL_RELOAD = IW'(SCAN_INTERVAL - 1);
    localparam logic [WW-1:0] WAIT_LIMIT      = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_SAT        = '1;

    state_t                  state_q, state_d;
    logic [INDEX_WIDTH-1:0]  index_q, index_d;
    logic                    lat_write_q, lat_write_d;
    logic [31:0]             lat_addr_q, lat_addr_d;
    logic [31:0]             lat_data_q, lat_data_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [IW-1:0]           interval_q, interval_d;
    logic                    scan_pending_q, scan_pending_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;

    logic                    tick;
    logic                    scan_start;
    logic                    scan_done;
    logic [NUM_CHANNELS-1:0] rise;
    logic [NUM_CHANNELS-1:0] level;

    assign tick       = (interval_q == '0);
    assign scan_done  = (state_q == SCAN) && (index_q == LAST_INDEX);
    assign scan_start = (state_q == IDLE) && scan_pending_q &&
                        ((wait_q >= WAIT_LIMIT) || !cpu_request);

    // Scan scheduling: free-running interval, pending flag and starvation counter.
    always_comb begin
        interval_d     = tick ? INTERVAL_RELOAD : interval_q - 1'b1;
        scan_pending_d = scan_pending_q;
        if (scan_done) begin
            scan_pending_d = 1'b0;
        end else if (tick) begin
            scan_pending_d = 1'b1;
        end
        wait_d = wait_q;
        if (scan_start) begin
            wait_d = '0;
        end else if (scan_pending_q && (state_q != SCAN) && (wait_q != WAIT_SAT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Port arbitration state machine.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        lat_write_d = lat_write_q;
        lat_addr_d  = lat_addr_q;
        lat_data_d  = lat_data_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d = SCAN;
                    index_d = '0;
                end else if (cpu_request) begin
                    state_d     = CPU_ACCESS;
                    lat_write_d = cpu_write;
                    lat_addr_d  = cpu_address;
                    lat_data_d  = cpu_data;
                end
            end
            CPU_ACCESS: begin
                rdata_d = lat_write_q ? 32'd0 : periph_read_data;
                state_d = RESPOND;
            end
            RESPOND: begin
                state_d = IDLE;
            end
            SCAN: begin
                index_d = index_q + 1'b1;
                if (index_q == LAST_INDEX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Event latch: a new rising edge wins over a same-cycle clear.
    always_comb begin
        pending_d = (pending_q & ~event_clear) | rise;
    end

    // All controller registers, synchronously reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            index_q        <= '0;
            lat_write_q    <= 1'b0;
            lat_addr_q     <= '0;
            lat_data_q     <= '0;
            rdata_q        <= '0;
            interval_q     <= INTERVAL_RELOAD;
            scan_pending_q <= 1'b0;
            wait_q         <= '0;
            pending_q      <= '0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            lat_write_q    <= lat_write_d;
            lat_addr_q     <= lat_addr_d;
            lat_data_q     <= lat_data_d;
            rdata_q        <= rdata_d;
            interval_q     <= interval_d;
            scan_pending_q <= scan_pending_d;
            wait_q         <= wait_d;
            pending_q      <= pending_d;
        end
    end

    // One debouncer per input channel, fed in turn by the scan.
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_channel
        channel_debouncer #(
            .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
        ) u_debouncer (
            .clock        (clock),
            .reset_n      (reset_n),
            .sample_valid ((state_q == SCAN) && (index_q == INDEX_WIDTH'(ch))),
            .sample       (periph_read_data[0]),
            .stable       (level[ch]),
            .rise         (rise[ch])
        );
    end

    // Port and CPU outputs decoded from registered state only.
    always_comb begin
        periph_address      = 32'd0;
        periph_data         = 32'd0;
        periph_should_write = 1'b0;
        if (state_q == CPU_ACCESS) begin
            periph_address      = lat_addr_q;
            periph_data         = lat_data_q;
            periph_should_write = lat_write_q;
        end else if (state_q == SCAN) begin
            periph_address = {{(32 - INDEX_WIDTH){1'b0}}, index_q};
        end
    end

    assign cpu_ready       = (state_q == RESPOND);
    assign cpu_read_data   = cpu_ready ? rdata_q : 32'd0;
    assign event_pending   = pending_q;
    assign debounced_level = level;
    assign irq             = |(pending_q & irq_mask);

endmodule

// File: tb/tb_peripheral_io_controller.sv
// Self-checking bench for peripheral_io_controller with a small behavioural
// peripherals model (inputs readable at address 0..3, LEDs at addresses 2/3).
module tb_peripheral_io_controller;
    import peripheral_ctrl_pkg::*;

    localparam int SI = 16;
    localparam int DC = 4;
    localparam int MW = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_request, cpu_write;
    logic [31:0] cpu_address, cpu_data;
    logic        cpu_ready;
    logic [31:0] cpu_read_data;
    logic [31:0] periph_address, periph_data;
    logic        periph_should_write;
    logic [31:0] periph_read_data;
    logic [3:0]  event_clear, irq_mask, event_pending, debounced_level;
    logic        irq;

    logic [3:0]  in_q;
    logic [1:0]  led_q = 2'b00;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    peripheral_io_controller #(
        .SCAN_INTERVAL  (SI),
        .DEBOUNCE_COUNT (DC),
        .MAX_WAIT       (MW)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .cpu_request         (cpu_request),
        .cpu_write           (cpu_write),
        .cpu_address         (cpu_address),
        .cpu_data            (cpu_data),
        .cpu_ready           (cpu_ready),
        .cpu_read_data       (cpu_read_data),
        .periph_address      (periph_address),
        .periph_data         (periph_data),
        .periph_should_write (periph_should_write),
        .periph_read_data    (periph_read_data),
        .event_clear         (event_clear),
        .irq_mask            (irq_mask),
        .event_pending       (event_pending),
        .debounced_level     (debounced_level),
        .irq                 (irq)
    );

    always #5 clock = ~clock;

    // Peripherals model: combinational input read, LED write on the clock edge.
    assign periph_read_data = (periph_address < 32'd4) ? {31'd0, in_q[periph_address[1:0]]} : 32'd0;
    always @(posedge clock) begin
        if (periph_should_write && periph_address == 32'd2) led_q[0] <= periph_data[0];
        if (periph_should_write && periph_address == 32'd3) led_q[1] <= periph_data[0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every cpu_ready pops the oldest expected read value.
    always @(negedge clock) begin
        if (cpu_ready) begin
            if (exp_q.size() == 0) begin
                check("cpu_ready with no outstanding request", 32'(exp_q.size()), 32'd1);
            end else begin
                check("cpu_read_data", cpu_read_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // Issue one CPU transaction and report latency and port write activity.
    task automatic cpu_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp, output int lat, output int wr_cycles,
                           output logic [31:0] wr_addr, output int ready_after_wr);
        int   last_wr = 0;
        logic got = 1'b0;
        exp_q.push_back(wr ? 32'd0 : exp);
        cpu_request = 1'b1;
        cpu_write   = wr;
        cpu_address = addr;
        cpu_data    = data;
        lat = 0; wr_cycles = 0; wr_addr = '0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(posedge clock); #1;
            lat++;
            if (periph_should_write) begin
                wr_cycles++;
                wr_addr = periph_address;
                last_wr = lat;
            end
            if (cpu_ready) got = 1'b1;
        end
        cpu_request = 1'b0;
        check("cpu_ready arrives", 32'(got), 32'd1);
        ready_after_wr = lat - last_wr;
    endtask

    // Wait for an idle controller with no scan pending or imminent.
    task automatic wait_quiet();
        for (int c = 0; c < 64; c++) begin
            @(posedge clock); #1;
            if (dut.state_q == IDLE && !dut.scan_pending_q && dut.interval_q > 4'd5) break;
        end
    endtask

    // Wait for n complete scans; returns on the last scan's final cycle.
    task automatic wait_scans(input int n);
        int count = 0;
        for (int c = 0; c < n * SI * 3 + 20 && count < n; c++) begin
            @(negedge clock);
            if (dut.state_q == SCAN && dut.index_q == 2'd3) count++;
        end
        check("scan count reached", 32'(count), 32'(n));
    endtask

    task automatic wait_scan_index(input logic [1:0] idx);
        logic found = 1'b0;
        for (int c = 0; c < SI * 3 && !found; c++) begin
            @(negedge clock);
            if (dut.state_q == SCAN && dut.index_q == idx) found = 1'b1;
        end
        check("scan index reached", 32'(found), 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  inputs;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_led;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          lat, wr_cycles, raw, scans;
        logic [31:0] wr_addr;
        logic        b2b_done;

        vecs[0] = '{1'b0, 32'd2, 32'd0, 4'b0100, 32'd1, 2'b00};
        vecs[1] = '{1'b0, 32'd0, 32'd0, 4'b0100, 32'd0, 2'b00};
        vecs[2] = '{1'b0, 32'd1, 32'd0, 4'b0010, 32'd1, 2'b00};
        vecs[3] = '{1'b0, 32'd3, 32'd0, 4'b1000, 32'd1, 2'b00};
        vecs[4] = '{1'b1, 32'd3, 32'd1, 4'b0000, 32'd0, 2'b10};
        vecs[5] = '{1'b1, 32'd2, 32'd1, 4'b0000, 32'd0, 2'b11};
        vecs[6] = '{1'b1, 32'd3, 32'd0, 4'b0000, 32'd0, 2'b01};
        vecs[7] = '{1'b0, 32'd2, 32'd0, 4'b1011, 32'd0, 2'b01};

        reset_n = 1'b0; cpu_request = 1'b0; cpu_write = 1'b0;
        cpu_address = '0; cpu_data = '0; event_clear = '0; irq_mask = '0; in_q = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset cpu_ready", 32'(cpu_ready), 32'd0);
        check("reset periph_address", periph_address, 32'd0);
        check("reset event_pending", 32'(event_pending), 32'd0);
        check("reset debounced_level", 32'(debounced_level), 32'd0);
        check("reset interval", 32'(dut.interval_q), 32'(SI - 1));
        reset_n = 1'b1;

        // Table-driven CPU loads and stores with no scan in the way.
        for (int i = 0; i < 8; i++) begin
            in_q = vecs[i].inputs;
            wait_quiet();
            cpu_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rdata,
                    lat, wr_cycles, wr_addr, raw);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d write cycles", i), 32'(wr_cycles), 32'(vecs[i].wr));
            if (vecs[i].wr) begin
                check($sformatf("vec%0d write address", i), wr_addr, vecs[i].addr);
                check($sformatf("vec%0d ready after write", i), 32'(raw), 32'd1);
            end
            check($sformatf("vec%0d leds", i), 32'(led_q), 32'(vecs[i].exp_led));
        end

        // Button 1 (ch 2) held high: event after the fourth scan.
        in_q = 4'b0100; irq_mask = 4'b0000;
        do_reset();
        wait_scans(3);
        check("ch2 pending after 3 scans", 32'(event_pending), 32'd0);
        check("ch2 level after 3 scans", 32'(debounced_level), 32'd0);
        wait_scans(1);
        check("ch2 pending after 4 scans", 32'(event_pending), 32'b0100);
        check("ch2 level after 4 scans", 32'(debounced_level), 32'b0100);
        check("irq masked", 32'(irq), 32'd0);
        irq_mask = 4'b0100; #1;
        check("irq enabled", 32'(irq), 32'd1);
        irq_mask = 4'b1011; #1;
        check("irq other mask", 32'(irq), 32'd0);
        irq_mask = 4'b0100;

        // Two-scan glitch on ch 0 must be filtered.
        in_q[0] = 1'b1;
        wait_scans(2);
        in_q[0] = 1'b0;
        wait_scans(3);
        check("glitch level", 32'(debounced_level), 32'b0100);
        check("glitch pending", 32'(event_pending), 32'b0100);

        // Plain write-1-to-clear.
        event_clear = 4'b0100;
        @(posedge clock); #1;
        event_clear = 4'b0000;
        check("clear pending", 32'(event_pending), 32'd0);
        check("clear irq", 32'(irq), 32'd0);

        // New ch 2 rising edge in the same cycle as a clear: set wins.
        in_q[2] = 1'b0;
        wait_scans(4);
        check("ch2 fell", 32'(debounced_level), 32'd0);
        in_q[2] = 1'b1;
        wait_scans(3);
        wait_scan_index(2'd2);
        event_clear = 4'b0100;
        @(posedge clock); #1;
        event_clear = 4'b0000;
        check("set beats clear", 32'(event_pending), 32'b0100);
        check("set beats clear irq", 32'(irq), 32'd1);

        // Reset in the middle of a scan.
        wait_scan_index(2'd1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("mid-scan reset periph_address", periph_address, 32'd0);
        check("mid-scan reset periph_should_write", 32'(periph_should_write), 32'd0);
        check("mid-scan reset cpu_ready", 32'(cpu_ready), 32'd0);
        check("mid-scan reset cpu_read_data", cpu_read_data, 32'd0);
        check("mid-scan reset event_pending", 32'(event_pending), 32'd0);
        check("mid-scan reset debounced_level", 32'(debounced_level), 32'd0);
        check("mid-scan reset irq", 32'(irq), 32'd0);
        check("mid-scan reset state", 32'(dut.state_q), 32'(IDLE));
        reset_n = 1'b1;

        // Back-to-back CPU loads while scans come due.
        in_q = 4'b1010;
        wait_quiet();
        b2b_done = 1'b0;
        scans = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    cpu_txn(1'b0, 32'(i % 4), 32'd0, 32'(in_q[i % 4]), lat, wr_cycles, wr_addr, raw);
                end
                b2b_done = 1'b1;
            end
            begin
                int   cyc = 0;
                int   tick_cyc = -1000;
                logic prev_pend = 1'b0;
                logic prev_scan = 1'b0;
                while (!b2b_done && cyc < 500) begin
                    @(negedge clock);
                    cyc++;
                    if (dut.scan_pending_q && !prev_pend && dut.state_q != SCAN) tick_cyc = cyc;
                    if (dut.state_q == SCAN && !prev_scan) begin
                        scans++;
                        // Deferral limit plus the CPU transaction already in flight.
                        check("scan deferral bound", 32'(cyc - tick_cyc <= MW + 3), 32'd1);
                    end
                    prev_pend = dut.scan_pending_q;
                    prev_scan = (dut.state_q == SCAN);
                end
            end
        join
        check("scans during cpu stream", 32'(scans >= 1), 32'd1);
        repeat (3) @(posedge clock);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
